// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider with start/busy/done handshake
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   t, s;
    logic [WIDTH-1:0] q_step, r_step;
    logic             accept, zero, run, last;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (start_i ? (zero ? FIN : RUN) : IDLE)
                : (state_q == RUN)  ? (last ? FIN : RUN)
                :                     IDLE;
    end

    always_comb begin
        busy_o = state_q == RUN;
        done_o = state_q == FIN;
    end

    // The kept partial remainder is always below the divisor, so WIDTH bits hold it.
    always_comb begin
        accept = state_q == IDLE && start_i;
        zero   = divisor_i == '0;
        run    = state_q == RUN;
        last   = run && cnt_q == CW'(WIDTH - 1);
        t      = {r_q, q_q[WIDTH-1]};
        s      = t + ~{1'b0, d_q} + (WIDTH+1)'(1);
        q_step = {q_q[WIDTH-2:0], ~s[WIDTH]};
        r_step = s[WIDTH] ? t[WIDTH-1:0] : s[WIDTH-1:0];
        q_d    = accept ? dividend_i : run ? q_step : q_q;
        r_d    = accept ? '0 : run ? r_step : r_q;
        d_d    = accept ? divisor_i : d_q;
        cnt_d  = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
        quo_d  = (accept && zero) ? '1 : last ? q_step : quo_q;
        rem_d  = (accept && zero) ? dividend_i : last ? r_step : rem_q;
        dbz_d  = (accept && zero) ? 1'b1 : last ? 1'b0 : dbz_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            r_q   <= r_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against a latency/arithmetic model
module tb_seq_divider;
    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    logic         busy_o, done_o, div_by_zero_o;
    logic [W-1:0] quotient_o, remainder_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    seq_divider #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i),
        .busy_o(busy_o), .done_o(done_o),
        .quotient_o(quotient_o), .remainder_o(remainder_o),
        .div_by_zero_o(div_by_zero_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ph counts cycles left until the result is shown (0 = idle, 1 = done cycle).
    int           ph = 0;
    logic [W-1:0] mq = '0, mr = '0, pq = '0, pr = '0;
    logic         mz = 1'b0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            ph <= 0;
            mq <= '0;
            mr <= '0;
            mz <= 1'b0;
        end else if (ph == 0) begin
            if (start_i && divisor_i == '0) begin
                ph <= 1;
                mq <= '1;
                mr <= dividend_i;
                mz <= 1'b1;
            end else if (start_i) begin
                ph <= W + 1;
                pq <= dividend_i / divisor_i;
                pr <= dividend_i % divisor_i;
            end
        end else begin
            ph <= ph - 1;
            if (ph == 2) begin
                mq <= pq;
                mr <= pr;
                mz <= 1'b0;
            end
        end
    end

    logic armed = 1'b0;
    logic prev_done = 1'b0;

    always @(posedge clk_i) armed <= 1'b1;

    always @(negedge clk_i) begin
        if (armed) begin
            check("busy", 32'(busy_o), 32'(ph > 1));
            check("done", 32'(done_o), 32'(ph == 1));
            check("quotient", 32'(quotient_o), 32'(mq));
            check("remainder", 32'(remainder_o), 32'(mr));
            check("div_by_zero", 32'(div_by_zero_o), 32'(mz));
            check("busy_done_overlap", 32'(busy_o && done_o), 32'(0));
            check("double_done", 32'(prev_done && done_o), 32'(0));
            prev_done <= done_o;
        end
    end

    task automatic divide(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int n, nb;
        @(negedge clk_i);
        start_i = 1'b1; dividend_i = a; divisor_i = b;
        @(negedge clk_i);
        start_i = 1'b0; dividend_i = W'($urandom); divisor_i = W'($urandom);
        n = 1; nb = 0;
        while (!done_o && n <= 20) begin
            nb += int'(busy_o);
            @(negedge clk_i);
            n++;
        end
        check("latency", 32'(n), (b == '0) ? 32'(1) : 32'(W + 1));
        check("busy_cycles", 32'(nb), (b == '0) ? 32'(0) : 32'(W));
        check("lit_quotient", 32'(quotient_o), 32'(eq));
        check("lit_remainder", 32'(remainder_o), 32'(er));
        check("lit_div_by_zero", 32'(div_by_zero_o), 32'(ez));
    endtask

    initial begin
        int nd, last_i, ndone;
        logic [W-1:0] gq, gr;
        repeat (2) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_done", 32'(done_o), 32'(0));
        check("rst_quotient", 32'(quotient_o), 32'(0));
        check("rst_remainder", 32'(remainder_o), 32'(0));
        check("rst_div_by_zero", 32'(div_by_zero_o), 32'(0));
        rst_i = 1'b0;

        divide(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        divide(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        divide(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        divide(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        divide(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
        divide(8'd77, 8'd0, 8'd255, 8'd77, 1'b1);
        divide(8'd10, 8'd3, 8'd3, 8'd1, 1'b0);

        // A Start pulsed mid-division must be dropped.
        @(negedge clk_i);
        start_i = 1'b1; dividend_i = 8'd100; divisor_i = 8'd9;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        start_i = 1'b1; dividend_i = 8'd50; divisor_i = 8'd5;
        @(negedge clk_i);
        start_i = 1'b0;
        nd = 0; gq = '0; gr = '0;
        repeat (15) begin
            if (done_o) begin nd++; gq = quotient_o; gr = remainder_o; end
            @(negedge clk_i);
        end
        check("ignored_start_dones", 32'(nd), 32'(1));
        check("ignored_start_quotient", 32'(gq), 32'(11));
        check("ignored_start_remainder", 32'(gr), 32'(1));

        // Reset abandons a division in progress.
        @(negedge clk_i);
        start_i = 1'b1; dividend_i = 8'd200; divisor_i = 8'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'(0));
        check("abort_done", 32'(done_o), 32'(0));
        check("abort_quotient", 32'(quotient_o), 32'(0));
        check("abort_remainder", 32'(remainder_o), 32'(0));
        nd = 0;
        repeat (12) begin
            nd += int'(done_o);
            @(negedge clk_i);
        end
        check("abort_no_done", 32'(nd), 32'(0));
        divide(8'd9, 8'd2, 8'd4, 8'd1, 1'b0);

        // Start held high: a result every WIDTH+2 cycles.
        start_i = 1'b1;
        last_i = -1; nd = 0;
        for (int i = 0; i < 60; i++) begin
            if (done_o) begin
                if (last_i >= 0) check("done_period", 32'(i - last_i), 32'(W + 2));
                last_i = i;
                nd++;
            end
            dividend_i = W'($urandom);
            divisor_i = W'($urandom_range(1, 255));
            @(negedge clk_i);
        end
        check("period_done_count", 32'(nd >= 5), 32'(1));

        ndone = 0;
        for (int i = 0; i < 20000 && ndone < 1000; i++) begin
            ndone += int'(done_o);
            case ($urandom_range(0, 15))
                0:       dividend_i = '0;
                1:       dividend_i = '1;
                default: dividend_i = W'($urandom);
            endcase
            case ($urandom_range(0, 15))
                0:       divisor_i = '0;
                1:       divisor_i = 8'd1;
                2:       divisor_i = '1;
                default: divisor_i = W'($urandom);
            endcase
            @(negedge clk_i);
        end
        check("random_done_count", 32'(ndone >= 1000), 32'(1));
        start_i = 1'b0;
        repeat (12) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
